reg_file_mp: RTL and testbench
==============================

REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 Parameter DATA_W, default 4, bits per entry.
REQ-002 Parameter ADDR_W, default 4, address width of every port.
REQ-003 Parameter DEPTH, default 16, number of entries; legal range 2..2**ADDR_W.
REQ-004 Parameter ZERO_REG, default 0; 1 = entry 0 always reads zero and ignores writes.
REQ-005 Parameter BYPASS, default 1; 1 = same-cycle write data forwarded to matching read port.
REQ-006 Parameter RD_REG, default 0; 0 = combinational read, 1 = registered read, latency 1.
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 write_enable  in  1  write strobe.
REQ-010 rw  in  ADDR_W  write address.
REQ-011 busw  in  DATA_W  write data.
REQ-012 clr  in  1  synchronous clear of all entries.
REQ-013 ra, rb  in  ADDR_W  read addresses, ports A and B.
REQ-014 qa, qb  out  DATA_W  read data, ports A and B.
REQ-015 va, vb  out  1  entry at ra/rb written since last reset/clear.
REQ-016 werr  out  1  registered one-cycle pulse: illegal write attempted.

Function
REQ-017 Legal write: write_enable=1, rw<DEPTH, not (ZERO_REG=1 and rw=0), clr=0; entry rw <= busw and valid[rw] <= 1 at rising edge.
REQ-018 Illegal write (rw>=DEPTH, or rw=0 with ZERO_REG=1): storage unchanged; werr=1 in following cycle only.
REQ-019 clr=1: all entries <= 0, all valid bits <= 0; clr overrides a simultaneous write; werr not asserted for that write.
REQ-020 Read, RD_REG=0: qa = entry[ra] combinationally; ra>=DEPTH gives qa=0, va=0; ZERO_REG=1 and ra=0 gives qa=0, va=1.
REQ-021 Bypass (BYPASS=1): when a legal write targets ra in the same cycle, qa=busw and va=1; BYPASS=0 gives old contents until the edge.
REQ-022 RD_REG=1: qa/va register the REQ-020/021 value at the rising edge; data visible one cycle after ra presented.
REQ-023 clr with RD_REG=1 and BYPASS=1: registered qa captures 0 and va captures 0 that edge.
REQ-024 Port B identical to port A using rb, qb, vb; ra=rb returns identical data on both.
REQ-025 Ports fully independent; no read blocks a write; one write per cycle.

Reset
REQ-026 rst=1 asynchronously forces all entries to 0, all valid bits to 0, werr=0, and registered qa/qb/va/vb to 0.
REQ-027 rst asserted mid-write discards that write; first legal write after deassertion takes effect on the first rising edge with rst=0.

Structure
REQ-028 Package reg_file_pkg holds default DATA_W/ADDR_W/DEPTH constants and the ZERO_REG/BYPASS/RD_REG mode constants.
REQ-029 One sub-module reg_file_rdport (address decode, range check, bypass mux, optional output register) instantiated twice, for ports A and B.
REQ-030 Storage and valid bitmap reside in reg_file_mp only.

Verification
REQ-031 rst=1 then release; read ra=0..15 -> qa=0000, va=0 for every address.
REQ-032 Write rw=0 busw=1111, then rw=4 busw=1010; ra=0, rb=4 -> qa=1111, qb=1010, va=vb=1 (ZERO_REG=0).
REQ-033 BYPASS=1, RD_REG=0: write rw=7 busw=0110 with ra=7 same cycle -> qa=0110 before edge; BYPASS=0 -> qa=0000.
REQ-034 ZERO_REG=1: write rw=0 busw=1111 -> werr=1 next cycle, qa=0000 at ra=0; DEPTH=12: write rw=13 -> werr=1, no entry changed.
REQ-035 clr=1 with write rw=3 busw=1001 same cycle -> after edge qa=0000, va=0 at ra=3; werr=0.
REQ-036 RD_REG=1: change ra from 0 to 4 -> qa shows entry 4 exactly one cycle later; rst asserted mid-cycle clears qa immediately.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared defaults and mode constants for the multi-port register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DEPTH  = 16;

  // Mode switches: ZERO_REG hardwires entry 0, BYPASS forwards same-cycle
  // write data to reads, RD_REG adds one cycle of read latency.
  localparam bit DEF_ZERO_REG = 1'b0;
  localparam bit DEF_BYPASS   = 1'b1;
  localparam bit DEF_RD_REG   = 1'b0;

endpackage

// File: rtl/reg_file_rdport.sv
// One read port: range check, entry select, zero-register and bypass
// override, optional output register.
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter bit ZERO_REG = DEF_ZERO_REG,
  parameter bit BYPASS   = DEF_BYPASS,
  parameter bit RD_REG   = DEF_RD_REG
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DEPTH-1:0][DATA_W-1:0]  entries,
  input  logic [DEPTH-1:0]              valid,
  input  logic                          wr_hit,
  input  logic [ADDR_W-1:0]             rw,
  input  logic [DATA_W-1:0]             busw,
  output logic [DATA_W-1:0]             q,
  output logic                          v
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] q_c;
  logic              v_c;

  // Combinational read value: out-of-range reads return 0/invalid.
  always_comb begin
    q_c = '0;
    v_c = 1'b0;
    if ({1'b0, addr} < DEPTH_L) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (addr == ADDR_W'(i)) begin
          q_c = entries[i];
          v_c = valid[i];
        end
      end
      if (ZERO_REG && addr == '0) begin
        q_c = '0;
        v_c = 1'b1;
      end else if (BYPASS && wr_hit && rw == addr) begin
        q_c = busw;
        v_c = 1'b1;
      end
    end
  end

  generate
    if (RD_REG) begin : g_reg
      // Registered read; with bypass a clear is forwarded as 0/invalid.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
          v <= 1'b0;
        end else if (BYPASS && clr) begin
          q <= '0;
          v <= 1'b0;
        end else begin
          q <= q_c;
          v <= v_c;
        end
      end
    end else begin : g_comb
      assign q = q_c;
      assign v = v_c;
    end
  endgenerate

endmodule

// File: rtl/reg_file_mp.sv
// Two-read, one-write register file with valid bitmap, clear and
// illegal-write flag.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter bit ZERO_REG = DEF_ZERO_REG,
  parameter bit BYPASS   = DEF_BYPASS,
  parameter bit RD_REG   = DEF_RD_REG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] busw,
  input  logic              clr,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic              va,
  output logic              vb,
  output logic              werr
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             valid;
  logic                         bad_addr;
  logic                         wr_legal;
  logic                         wr_illegal;

  assign bad_addr   = ({1'b0, rw} >= DEPTH_L) || (ZERO_REG && rw == '0);
  assign wr_legal   = write_enable && !clr && !bad_addr;
  assign wr_illegal = write_enable && !clr && bad_addr;

  // Storage and valid bitmap; clear wins over a simultaneous write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem   <= '0;
      valid <= '0;
    end else if (clr) begin
      mem   <= '0;
      valid <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_legal && rw == ADDR_W'(i)) begin
          mem[i]   <= busw;
          valid[i] <= 1'b1;
        end
      end
    end
  end

  // One-cycle pulse flagging a rejected write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) werr <= 1'b0;
    else     werr <= wr_illegal;
  end

  reg_file_rdport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .RD_REG(RD_REG)
  ) u_port_a (
    .clk(clk), .rst(rst), .clr(clr), .addr(ra), .entries(mem), .valid(valid),
    .wr_hit(wr_legal), .rw(rw), .busw(busw), .q(qa), .v(va)
  );

  reg_file_rdport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .RD_REG(RD_REG)
  ) u_port_b (
    .clk(clk), .rst(rst), .clr(clr), .addr(rb), .entries(mem), .valid(valid),
    .wr_hit(wr_legal), .rw(rw), .busw(busw), .q(qb), .v(vb)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench: four configurations driven by common stimulus and
// compared against a per-configuration reference model.
module tb_reg_file_mp;

  localparam int NC = 4;
  localparam int C_DEPTH [NC] = '{16, 12, 16, 16};
  localparam bit C_ZR    [NC] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit C_BY    [NC] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam bit C_RR    [NC] = '{1'b0, 1'b1, 1'b1, 1'b0};

  logic clk;
  logic rst, write_enable, clr;
  logic [3:0] rw, busw, ra, rb;
  logic [NC-1:0][3:0] qa, qb;
  logic [NC-1:0] va, vb, werr;

  typedef struct packed {
    logic [NC-1:0][3:0] qa;
    logic [NC-1:0][3:0] qb;
    logic [NC-1:0]      va;
    logic [NC-1:0]      vb;
    logic [NC-1:0]      werr;
    int                 cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cycle    = 0;

  // Reference state per configuration
  logic [3:0] m_mem [NC][16];
  logic       m_val [NC][16];
  logic [3:0] m_qa [NC], m_qb [NC];
  logic       m_va [NC], m_vb [NC], m_werr [NC];

  reg_file_mp dut0 (.clk(clk), .rst(rst), .write_enable(write_enable), .rw(rw),
    .busw(busw), .clr(clr), .ra(ra), .rb(rb), .qa(qa[0]), .qb(qb[0]),
    .va(va[0]), .vb(vb[0]), .werr(werr[0]));

  reg_file_mp #(.DEPTH(12), .ZERO_REG(1'b1), .BYPASS(1'b0), .RD_REG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .write_enable(write_enable), .rw(rw),
    .busw(busw), .clr(clr), .ra(ra), .rb(rb), .qa(qa[1]), .qb(qb[1]),
    .va(va[1]), .vb(vb[1]), .werr(werr[1]));

  reg_file_mp #(.DEPTH(16), .ZERO_REG(1'b0), .BYPASS(1'b1), .RD_REG(1'b1)) dut2 (
    .clk(clk), .rst(rst), .write_enable(write_enable), .rw(rw),
    .busw(busw), .clr(clr), .ra(ra), .rb(rb), .qa(qa[2]), .qb(qb[2]),
    .va(va[2]), .vb(vb[2]), .werr(werr[2]));

  reg_file_mp #(.DEPTH(16), .ZERO_REG(1'b0), .BYPASS(1'b0), .RD_REG(1'b0)) dut3 (
    .clk(clk), .rst(rst), .write_enable(write_enable), .rw(rw),
    .busw(busw), .clr(clr), .ra(ra), .rb(rb), .qa(qa[3]), .qb(qb[3]),
    .va(va[3]), .vb(vb[3]), .werr(werr[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit legal(int k, logic we, logic [3:0] w, logic c);
    return we && !c && (int'(w) < C_DEPTH[k]) && !(C_ZR[k] && w == 4'd0);
  endfunction

  // What a read of address a shows this cycle before the clock edge
  task automatic model_read(input int k, input logic [3:0] a, input logic we,
                            input logic [3:0] w, input logic [3:0] d, input logic c,
                            output logic [3:0] q, output logic v);
    if (int'(a) >= C_DEPTH[k]) begin
      q = 4'd0; v = 1'b0;
    end else if (C_ZR[k] && a == 4'd0) begin
      q = 4'd0; v = 1'b1;
    end else if (C_BY[k] && legal(k, we, w, c) && w == a) begin
      q = d; v = 1'b1;
    end else begin
      q = m_mem[k][a]; v = m_val[k][a];
    end
  endtask

  task automatic step(input logic r, input logic we, input logic [3:0] w,
                      input logic [3:0] d, input logic c,
                      input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    logic [3:0] ca, cb;
    logic cva, cvb;
    @(posedge clk);
    #1;
    rst = r; write_enable = we; rw = w; busw = d; clr = c; ra = a; rb = b;
    e = '0;
    e.cyc = cycle;
    for (int k = 0; k < NC; k++) begin
      if (r) begin
        for (int i = 0; i < 16; i++) begin
          m_mem[k][i] = 4'd0; m_val[k][i] = 1'b0;
        end
        m_qa[k] = 4'd0; m_qb[k] = 4'd0; m_va[k] = 1'b0; m_vb[k] = 1'b0;
        m_werr[k] = 1'b0;
      end
      model_read(k, a, we, w, d, c, ca, cva);
      model_read(k, b, we, w, d, c, cb, cvb);
      e.qa[k]   = C_RR[k] ? m_qa[k] : ca;
      e.va[k]   = C_RR[k] ? m_va[k] : cva;
      e.qb[k]   = C_RR[k] ? m_qb[k] : cb;
      e.vb[k]   = C_RR[k] ? m_vb[k] : cvb;
      e.werr[k] = m_werr[k];
      if (!r) begin
        if (C_BY[k] && c) begin
          m_qa[k] = 4'd0; m_va[k] = 1'b0; m_qb[k] = 4'd0; m_vb[k] = 1'b0;
        end else begin
          m_qa[k] = ca; m_va[k] = cva; m_qb[k] = cb; m_vb[k] = cvb;
        end
        m_werr[k] = we && !c && !legal(k, we, w, c);
        if (c) begin
          for (int i = 0; i < 16; i++) begin
            m_mem[k][i] = 4'd0; m_val[k][i] = 1'b0;
          end
        end else if (legal(k, we, w, c)) begin
          m_mem[k][w] = d; m_val[k][w] = 1'b1;
        end
      end
    end
    sb.push_back(e);
    cycle++;
  endtask

  task automatic chk(input string name, input int k, input int cyc,
                     input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, got, want);
  endtask

  // Monitor: outputs are settled mid-cycle, compare against the oldest entry
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      for (int k = 0; k < NC; k++) begin
        chk("qa", k, e.cyc, qa[k], e.qa[k]);
        chk("qb", k, e.cyc, qb[k], e.qb[k]);
        chk("va", k, e.cyc, {3'b0, va[k]}, {3'b0, e.va[k]});
        chk("vb", k, e.cyc, {3'b0, vb[k]}, {3'b0, e.vb[k]});
        chk("werr", k, e.cyc, {3'b0, werr[k]}, {3'b0, e.werr[k]});
      end
    end
  end

  initial begin
    rst = 1'b1; write_enable = 1'b0; clr = 1'b0;
    rw = 4'd0; busw = 4'd0; ra = 4'd0; rb = 4'd0;

    // Reset, then sweep every address on both ports
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 4'(i), 4'(15 - i));

    // Basic writes and reads
    step(0, 1, 4'd0, 4'hF, 0, 4'd0, 4'd4);
    step(0, 1, 4'd4, 4'hA, 0, 4'd0, 4'd4);
    step(0, 0, 0, 0, 0, 4'd0, 4'd4);
    step(0, 0, 0, 0, 0, 4'd0, 4'd4);

    // Same-cycle write/read of address 7
    step(0, 1, 4'd7, 4'h6, 0, 4'd7, 4'd7);
    step(0, 0, 0, 0, 0, 4'd7, 4'd7);

    // Zero-register and out-of-range writes
    step(0, 1, 4'd0, 4'hF, 0, 4'd0, 4'd0);
    step(0, 1, 4'd13, 4'h5, 0, 4'd0, 4'd13);
    step(0, 0, 0, 0, 0, 4'd13, 4'd0);
    step(0, 0, 0, 0, 0, 4'd0, 4'd13);

    // Clear overriding a write
    step(0, 1, 4'd3, 4'h9, 1, 4'd3, 4'd4);
    step(0, 0, 0, 0, 0, 4'd3, 4'd4);
    step(0, 0, 0, 0, 0, 4'd3, 4'd4);

    // Registered read latency and asynchronous reset mid-write
    step(0, 1, 4'd4, 4'hC, 0, 4'd0, 4'd0);
    step(0, 0, 0, 0, 0, 4'd0, 4'd0);
    step(0, 0, 0, 0, 0, 4'd4, 4'd4);
    step(0, 0, 0, 0, 0, 4'd4, 4'd4);
    step(1, 1, 4'd5, 4'hA, 0, 4'd4, 4'd5);
    step(0, 1, 4'd6, 4'h3, 0, 4'd5, 4'd6);
    step(0, 0, 0, 0, 0, 4'd6, 4'd5);
    step(0, 0, 0, 0, 0, 4'd6, 4'd5);

    // Random traffic
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
